// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one spi_core master between NREQ requesters,
// granting round-robin and running each burst as single-word transactions.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   req               per-requester level request, held until its done pulse
//   len               per-requester burst length (words = len + 1)
//   cfg               per-requester {cpol, cpha, clk_div[7:0]}
//   tx_data           per-requester next word to send
//   gnt               one-hot current owner
//   tx_ack            pulse: owner's tx_data word consumed
//   rx_data           last received word (shared)
//   rx_valid          pulse to owner: rx_data valid
//   done              pulse to owner: burst complete
//   cs_n              active-low chip selects, low for the whole burst
//   core_*            spi_core control, config and data
//   core_busy         spi_core busy
//   core_rx_data      spi_core received word
module spi_xfer_arbiter #(
    parameter int NREQ    = 2,
    parameter int D_WIDTH = 8,
    parameter int LEN_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   len,
    input  logic [NREQ*10-1:0]      cfg,
    input  logic [NREQ*D_WIDTH-1:0] tx_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         tx_ack,
    output logic [D_WIDTH-1:0]      rx_data,
    output logic [NREQ-1:0]         rx_valid,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         cs_n,
    output logic                    core_enable,
    output logic                    core_cont,
    output logic                    core_cpol,
    output logic                    core_cpha,
    output logic [7:0]              core_clk_div,
    output logic [D_WIDTH-1:0]      core_tx_data,
    input  logic                    core_busy,
    input  logic [D_WIDTH-1:0]      core_rx_data
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    gnt_d;
    logic [NREQ-1:0]    tx_ack_d;
    logic [NREQ-1:0]    rx_valid_d;
    logic [NREQ-1:0]    done_d;
    logic [NREQ-1:0]    cs_n_d;
    logic [D_WIDTH-1:0] rx_data_d;
    logic               core_enable_d;
    logic               core_cpol_d;
    logic               core_cpha_d;
    logic [7:0]         core_clk_div_d;
    logic [D_WIDTH-1:0] core_tx_data_d;

    logic [NREQ-1:0]    req_avail;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [9:0]         pick_cfg;
    logic [LEN_W-1:0]   pick_len;
    logic [D_WIDTH-1:0] own_tx;
    logic [NREQ-1:0]    own_oh;
    logic [IDX_W-1:0]   rr_next;

    assign core_cont = 1'b0;

    // A requester whose done pulse is visible this cycle has not yet had
    // a chance to drop req, so its request is treated as stale.
    assign req_avail = req & ~done;

    assign own_oh  = NREQ'(1) << own_q;
    assign rr_next = (own_q == IDX_W'(NREQ - 1)) ? '0 : own_q + 1'b1;

    // Round-robin pick: first pass covers rr_q..NREQ-1, second pass wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_avail[k] && (IDX_W'(k) >= rr_q)) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_avail[k]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        pick_cfg = '0;
        pick_len = '0;
        own_tx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_cfg = cfg[k*10 +: 10];
                pick_len = len[k*LEN_W +: LEN_W];
            end
            if (own_q == IDX_W'(k)) begin
                own_tx = tx_data[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        own_d          = own_q;
        cnt_d          = cnt_q;
        gnt_d          = gnt;
        cs_n_d         = cs_n;
        tx_ack_d       = '0;
        rx_valid_d     = '0;
        done_d         = '0;
        core_enable_d  = 1'b0;
        rx_data_d      = rx_data;
        core_cpol_d    = core_cpol;
        core_cpha_d    = core_cpha;
        core_clk_div_d = core_clk_div;
        core_tx_data_d = core_tx_data;

        unique case (state_q)
            S_SYNC: begin
                if (!core_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pick_found) begin
                    own_d          = pick_idx;
                    gnt_d          = NREQ'(1) << pick_idx;
                    cs_n_d         = ~(NREQ'(1) << pick_idx);
                    core_cpol_d    = pick_cfg[9];
                    core_cpha_d    = pick_cfg[8];
                    core_clk_div_d = pick_cfg[7:0];
                    cnt_d          = pick_len;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                core_tx_data_d = own_tx;
                tx_ack_d       = own_oh;
                state_d        = S_START;
            end
            S_START: begin
                core_enable_d = 1'b1;
                state_d       = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (core_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!core_busy) begin
                    rx_data_d  = core_rx_data;
                    rx_valid_d = own_oh;
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FIN: begin
                cs_n_d  = '1;
                done_d  = own_oh;
                gnt_d   = '0;
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_SYNC;
            rr_q         <= '0;
            own_q        <= '0;
            cnt_q        <= '0;
            gnt          <= '0;
            tx_ack       <= '0;
            rx_valid     <= '0;
            done         <= '0;
            cs_n         <= '1;
            core_enable  <= 1'b0;
            core_cpol    <= 1'b0;
            core_cpha    <= 1'b0;
            core_clk_div <= '0;
            core_tx_data <= '0;
            rx_data      <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            own_q        <= own_d;
            cnt_q        <= cnt_d;
            gnt          <= gnt_d;
            tx_ack       <= tx_ack_d;
            rx_valid     <= rx_valid_d;
            done         <= done_d;
            cs_n         <= cs_n_d;
            core_enable  <= core_enable_d;
            core_cpol    <= core_cpol_d;
            core_cpha    <= core_cpha_d;
            core_clk_div <= core_clk_div_d;
            core_tx_data <= core_tx_data_d;
            rx_data      <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: randomized bench for spi_xfer_arbiter with a
// behavioural spi_core slave and per-requester burst models.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam logic [7:0] KEY = 8'h99;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*LW-1:0] len;
    logic [NREQ*10-1:0] cfg;
    logic [NREQ*DW-1:0] tx_data;
    logic [NREQ-1:0]   gnt, tx_ack, rx_valid, done, cs_n;
    logic [DW-1:0]     rx_data;
    logic              core_enable, core_cont, core_cpol, core_cpha;
    logic [7:0]        core_clk_div;
    logic [DW-1:0]     core_tx_data;
    logic              core_busy;
    logic [DW-1:0]     core_rx_data;

    always #5 clock = ~clock;

    spi_xfer_arbiter #(.NREQ(NREQ), .D_WIDTH(DW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset), .req(req), .len(len), .cfg(cfg),
        .tx_data(tx_data), .gnt(gnt), .tx_ack(tx_ack), .rx_data(rx_data),
        .rx_valid(rx_valid), .done(done), .cs_n(cs_n),
        .core_enable(core_enable), .core_cont(core_cont),
        .core_cpol(core_cpol), .core_cpha(core_cpha),
        .core_clk_div(core_clk_div), .core_tx_data(core_tx_data),
        .core_busy(core_busy), .core_rx_data(core_rx_data)
    );

    // Behavioural spi_core: busy for a random few cycles per enable,
    // returns the transmitted word XOR KEY.
    logic       slv_busy;
    logic       hold_busy;
    int         slv_cnt;
    logic [7:0] slv_tx;
    assign core_busy = slv_busy | hold_busy;

    always @(posedge clock) begin
        if (reset) begin
            slv_busy     <= 1'b0;
            slv_cnt      <= 0;
            core_rx_data <= '0;
        end else if (slv_busy) begin
            if (slv_cnt <= 1) begin
                slv_busy     <= 1'b0;
                core_rx_data <= slv_tx ^ KEY;
            end else begin
                slv_cnt <= slv_cnt - 1;
            end
        end else if (core_enable && !hold_busy) begin
            slv_busy <= 1'b1;
            slv_tx   <= core_tx_data;
            slv_cnt  <= int'($urandom_range(1, 5));
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Requester / scoreboard model
    logic [7:0] words  [NREQ][16];
    logic [7:0] rx_log [NREQ][16];
    logic [9:0] cur_cfg [NREQ];
    int cur_len [NREQ];
    int sent [NREQ];
    int recv [NREQ];
    int ack_cnt [NREQ];
    int rx_cnt [NREQ];
    int done_cnt [NREQ];
    int jobs_left [NREQ];
    int refill_len [NREQ];
    int grants [$];
    int rr_m;
    int cur_own;
    int en_cnt;
    logic [9:0] last_en_cfg;
    logic [NREQ-1:0] gnt_last;
    logic [NREQ-1:0] cs_low_seen;
    logic en_last;

    task automatic new_job(input int i, input int l, input logic [9:0] c);
        cur_len[i] = l;
        cur_cfg[i] = c;
        sent[i] = 0;
        recv[i] = 0;
        for (int k = 0; k < 16; k++) words[i][k] = 8'($urandom);
        len[i*LW +: LW] = LW'(l);
        cfg[i*10 +: 10] = c;
        tx_data[i*DW +: DW] = words[i][0];
        req[i] = 1'b1;
    endtask

    task automatic model_clear();
        req = '0;
        rr_m = 0;
        cur_own = 0;
        en_cnt = 0;
        gnt_last = '0;
        en_last = 1'b0;
        cs_low_seen = '0;
        grants.delete();
        for (int i = 0; i < NREQ; i++) begin
            jobs_left[i] = 0;
            refill_len[i] = -1;
            sent[i] = 0;
            recv[i] = 0;
            ack_cnt[i] = 0;
            rx_cnt[i] = 0;
            done_cnt[i] = 0;
            cur_len[i] = 0;
            cur_cfg[i] = '0;
        end
    endtask

    // One clock of requester behaviour plus event scoreboarding.
    task automatic tick();
        logic [NREQ-1:0] req_e, done_e;
        int o, exp_w, j, ws;
        req_e = req;
        done_e = done;
        @(negedge clock);
        n_tests++;
        if (((gnt & (gnt - 1'b1)) != '0) || (cs_n !== ~gnt) ||
            (core_cont !== 1'b0)) begin
            n_fail++;
            $display("FAIL invariant: gnt=%b cs_n=%b cont=%b",
                     gnt, cs_n, core_cont);
        end
        cs_low_seen |= ~cs_n;
        if (gnt !== '0 && gnt_last === '0) begin
            o = -1;
            for (int k = 0; k < NREQ; k++) if (gnt[k] === 1'b1) o = k;
            exp_w = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (rr_m + k) % NREQ;
                if (exp_w < 0 && req_e[j] && !done_e[j]) exp_w = j;
            end
            cur_own = (o < 0) ? 0 : o;
            n_tests++;
            if (o !== exp_w ||
                {core_cpol, core_cpha, core_clk_div} !== cur_cfg[cur_own]) begin
                n_fail++;
                $display("FAIL grant: owner=%0d want %0d cfg=%h want %h", o, exp_w,
                         {core_cpol, core_cpha, core_clk_div}, cur_cfg[cur_own]);
            end
            grants.push_back(o);
            // Config and length must have been captured at the grant.
            len[cur_own*LW +: LW] = LW'($urandom);
            cfg[cur_own*10 +: 10] = 10'($urandom);
        end
        if (tx_ack !== '0) begin
            ws = (sent[cur_own] > 15) ? 15 : sent[cur_own];
            n_tests++;
            if (tx_ack !== gnt || core_tx_data !== words[cur_own][ws]) begin
                n_fail++;
                $display("FAIL tx_ack: ack=%b gnt=%b data=%h want %h",
                         tx_ack, gnt, core_tx_data, words[cur_own][ws]);
            end
            sent[cur_own]++;
            ack_cnt[cur_own]++;
            ws = (sent[cur_own] > 15) ? 15 : sent[cur_own];
            tx_data[cur_own*DW +: DW] = words[cur_own][ws];
        end
        if (core_enable === 1'b1) begin
            n_tests++;
            if (en_last ||
                {core_cpol, core_cpha, core_clk_div} !== cur_cfg[cur_own]) begin
                n_fail++;
                $display("FAIL enable: prev=%b cfg=%h want %h", en_last,
                         {core_cpol, core_cpha, core_clk_div}, cur_cfg[cur_own]);
            end
            en_cnt++;
            last_en_cfg = {core_cpol, core_cpha, core_clk_div};
        end
        if (rx_valid !== '0) begin
            ws = (recv[cur_own] > 15) ? 15 : recv[cur_own];
            n_tests++;
            if (rx_valid !== gnt || rx_data !== (words[cur_own][ws] ^ KEY)) begin
                n_fail++;
                $display("FAIL rx_valid: v=%b gnt=%b data=%h want %h", rx_valid,
                         gnt, rx_data, words[cur_own][ws] ^ KEY);
            end
            rx_log[cur_own][ws] = rx_data;
            recv[cur_own]++;
            rx_cnt[cur_own]++;
        end
        if (done !== '0) begin
            n_tests++;
            if (done !== (NREQ'(1) << cur_own) ||
                sent[cur_own] != cur_len[cur_own] + 1 ||
                recv[cur_own] != cur_len[cur_own] + 1) begin
                n_fail++;
                $display("FAIL done: done=%b own=%0d sent=%0d recv=%0d want %0d",
                         done, cur_own, sent[cur_own], recv[cur_own],
                         cur_len[cur_own] + 1);
            end
            done_cnt[cur_own]++;
            rr_m = (cur_own + 1) % NREQ;
            if (jobs_left[cur_own] > 0) begin
                jobs_left[cur_own]--;
                new_job(cur_own, (refill_len[cur_own] < 0) ?
                        int'($urandom_range(0, 5)) : refill_len[cur_own],
                        10'($urandom));
            end else begin
                req[cur_own] = 1'b0;
            end
        end
        gnt_last = gnt;
        en_last = core_enable;
    endtask

    task automatic wait_done(input int i, input int target, input int budget,
                             input string name);
        int c;
        c = 0;
        while (done_cnt[i] < target && c < budget) begin
            tick();
            c++;
        end
        n_tests++;
        if (done_cnt[i] < target) begin
            n_fail++;
            $display("FAIL %s timeout: done=%0d want %0d", name,
                     done_cnt[i], target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hold_busy = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        n_tests++;
        if (gnt !== '0 || cs_n !== '1 || tx_ack !== '0 || rx_valid !== '0 ||
            done !== '0 || core_enable !== 1'b0 || core_cont !== 1'b0 ||
            core_cpol !== 1'b0 || core_cpha !== 1'b0 || core_clk_div !== '0 ||
            core_tx_data !== '0 || rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b cs_n=%b en=%b div=%h tx=%h rx=%h",
                     gnt, cs_n, core_enable, core_clk_div, core_tx_data, rx_data);
        end
        reset = 1'b0;
        new_job(0, 0, 10'h003);
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (gnt !== '0) begin
                n_fail++;
                $display("FAIL sync_hold: gnt=%b want 00", gnt);
            end
        end
        hold_busy = 1'b0;
        wait_done(0, 1, 100, "powerup_first");
    endtask

    task automatic test_single();
        int e0;
        cs_low_seen = '0;
        e0 = en_cnt;
        new_job(0, 0, 10'h002);
        words[0][0] = 8'hA5;
        tx_data[0 +: DW] = 8'hA5;
        wait_done(0, done_cnt[0] + 1, 100, "single");
        repeat (3) tick();
        n_tests++;
        if (en_cnt - e0 != 1 || sent[0] != 1 || recv[0] != 1 ||
            rx_log[0][0] !== 8'h3C || cs_low_seen !== 2'b01) begin
            n_fail++;
            $display("FAIL single: en=%0d ack=%0d rx=%0d data=%h cs_seen=%b want 1/1/1/3c/01",
                     en_cnt - e0, sent[0], recv[0], rx_log[0][0], cs_low_seen);
        end
    endtask

    task automatic test_multi();
        int e0;
        e0 = en_cnt;
        new_job(1, 2, 10'h304);
        words[1][0] = 8'h11;
        words[1][1] = 8'h22;
        words[1][2] = 8'h33;
        tx_data[DW +: DW] = 8'h11;
        wait_done(1, done_cnt[1] + 1, 200, "multi");
        n_tests++;
        if (en_cnt - e0 != 3 || sent[1] != 3 || recv[1] != 3 ||
            last_en_cfg !== 10'h304) begin
            n_fail++;
            $display("FAIL multi_counts: en=%0d ack=%0d rx=%0d cfg=%h want 3/3/3/304",
                     en_cnt - e0, sent[1], recv[1], last_en_cfg);
        end
        n_tests++;
        if (rx_log[1][0] !== (8'h11 ^ KEY) || rx_log[1][1] !== (8'h22 ^ KEY) ||
            rx_log[1][2] !== (8'h33 ^ KEY)) begin
            n_fail++;
            $display("FAIL multi_order: got %h %h %h want 88 bb aa",
                     rx_log[1][0], rx_log[1][1], rx_log[1][2]);
        end
    endtask

    task automatic test_alternate();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        refill_len[0] = 0;
        refill_len[1] = 0;
        jobs_left[0] = 1;
        jobs_left[1] = 1;
        new_job(0, 0, 10'($urandom));
        new_job(1, 0, 10'($urandom));
        wait_done(1, 2, 300, "alternate");
        n_tests++;
        if (grants.size() != 4) begin
            n_fail++;
            $display("FAIL alternate_count: grants=%0d want 4", grants.size());
        end
        for (int k = 0; k < grants.size() && k < 4; k++) begin
            n_tests++;
            if (grants[k] != k % 2) begin
                n_fail++;
                $display("FAIL alternate_seq[%0d]: owner=%0d want %0d",
                         k, grants[k], k % 2);
            end
        end
    endtask

    task automatic test_max_len();
        new_job(0, 15, 10'($urandom));
        wait_done(0, done_cnt[0] + 1, 400, "max_len");
        n_tests++;
        if (sent[0] != 16 || recv[0] != 16) begin
            n_fail++;
            $display("FAIL max_len: ack=%0d rx=%0d want 16/16", sent[0], recv[0]);
        end
    endtask

    task automatic test_drop_req();
        int c, d0;
        d0 = done_cnt[0];
        new_job(0, 3, 10'($urandom));
        c = 0;
        while (sent[0] < 1 && c < 50) begin
            tick();
            c++;
        end
        req[0] = 1'b0;
        wait_done(0, d0 + 1, 200, "drop_req");
        n_tests++;
        if (sent[0] != 4 || recv[0] != 4) begin
            n_fail++;
            $display("FAIL drop_req: ack=%0d rx=%0d want 4/4", sent[0], recv[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int c, e0;
        e0 = en_cnt;
        new_job(0, 3, 10'($urandom));
        c = 0;
        while (en_cnt < e0 + 2 && c < 200) begin
            tick();
            c++;
        end
        n_tests++;
        if (en_cnt < e0 + 2) begin
            n_fail++;
            $display("FAIL midreset_reach: enables=%0d want 2", en_cnt - e0);
        end
        tick();
        tick();
        reset = 1'b1;
        hold_busy = 1'b1;
        @(negedge clock);
        n_tests++;
        if (cs_n !== '1 || gnt !== '0 || done !== '0) begin
            n_fail++;
            $display("FAIL midreset_out: cs_n=%b gnt=%b done=%b want 11/00/00",
                     cs_n, gnt, done);
        end
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        new_job(1, 0, 10'($urandom));
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (gnt !== '0 || done !== '0) begin
                n_fail++;
                $display("FAIL midreset_sync: gnt=%b done=%b want 00/00", gnt, done);
            end
        end
        hold_busy = 1'b0;
        wait_done(1, 1, 100, "midreset_resume");
    endtask

    task automatic test_random();
        int tgt [NREQ];
        int c;
        logic all_done;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                jobs_left[i] = int'($urandom_range(0, 3));
                refill_len[i] = -1;
                tgt[i] = done_cnt[i] + jobs_left[i] + 1;
            end
            new_job(0, int'($urandom_range(0, 5)), 10'($urandom));
            repeat ($urandom_range(0, 15)) tick();
            if (req[1] == 1'b0 && done_cnt[1] < tgt[1])
                new_job(1, int'($urandom_range(0, 5)), 10'($urandom));
            c = 0;
            all_done = 1'b0;
            while (!all_done && c < 3000) begin
                tick();
                c++;
                all_done = 1'b1;
                for (int i = 0; i < NREQ; i++)
                    if (done_cnt[i] < tgt[i]) all_done = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                n_tests++;
                if (done_cnt[i] != tgt[i]) begin
                    n_fail++;
                    $display("FAIL random[%0d] req%0d: bursts=%0d want %0d",
                             r, i, done_cnt[i], tgt[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        hold_busy = 1'b1;
        req = '0;
        len = '0;
        cfg = '0;
        tx_data = '0;
        test_reset();
        test_single();
        test_multi();
        test_alternate();
        test_max_len();
        test_drop_req();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
